calc_seq_ctrl: RTL and testbench

Sequencing controller for the mini-calculator ALU. It accepts keypad tokens, holds operands A and B plus the operator, and issues one-hot ALU operations. It waits out the ALU `busy` handshake, latches and formats the result for display, and reports divide-by-zero and ALU timeout errors. It sits between the keypad decoder and the ALU.

---
 rtl/calc_seq_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller between the keypad decoder and the mini-calculator ALU.
// Collects A, operator and B, issues a one-hot ALU op, and formats the result or error.
module calc_seq_ctrl #(
    parameter int TIMEOUT = 31
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic       alu_busy,
    input  logic [7:0] alu_o,
    output logic [7:0] disp,
    output logic       neg,
    output logic       result_valid,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GOT_A,
        S_GOT_OP,
        S_GOT_B,
        S_ISSUE,
        S_WAIT,
        S_SHOW,
        S_ERR
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0001;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    // Last count value before the counter would reach TIMEOUT.
    localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

    state_t     state, state_d;
    logic [3:0] a_reg, a_d;
    logic [3:0] b_reg, b_d;
    logic [3:0] op_reg, op_d;
    logic [4:0] wait_cnt, wait_cnt_d;
    logic [3:0] alu_op_d, alu_a_d, alu_b_d;
    logic [7:0] disp_d;
    logic       neg_d, result_valid_d, err_d, key_ready_d;
    logic [1:0] err_code_d;

    logic       accept, is_digit, is_oper, is_eq, is_clr;
    logic [3:0] oper_onehot;

    assign accept   = key_valid && key_ready;
    assign is_digit = key_code <= 4'd9;
    assign is_oper  = (key_code >= 4'd10) && (key_code <= 4'd13);
    assign is_eq    = key_code == 4'd14;
    assign is_clr   = key_code == 4'd15;

    always_comb begin
        case (key_code)
            4'd10:   oper_onehot = OP_ADD;
            4'd11:   oper_onehot = OP_SUB;
            4'd12:   oper_onehot = OP_MUL;
            4'd13:   oper_onehot = OP_DIV;
            default: oper_onehot = '0;
        endcase
    end

    always_comb begin
        state_d        = state;
        a_d            = a_reg;
        b_d            = b_reg;
        op_d           = op_reg;
        wait_cnt_d     = wait_cnt;
        alu_op_d       = '0;
        alu_a_d        = alu_a;
        alu_b_d        = alu_b;
        disp_d         = disp;
        neg_d          = neg;
        result_valid_d = result_valid;
        err_d          = err;
        err_code_d     = err_code;

        if (accept && is_clr) begin
            state_d        = S_IDLE;
            a_d            = '0;
            b_d            = '0;
            op_d           = '0;
            alu_a_d        = '0;
            alu_b_d        = '0;
            disp_d         = '0;
            neg_d          = 1'b0;
            result_valid_d = 1'b0;
            err_d          = 1'b0;
            err_code_d     = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_digit) begin
                        a_d     = key_code;
                        disp_d  = {4'd0, key_code};
                        state_d = S_GOT_A;
                    end
                end
                S_GOT_A: begin
                    if (accept && is_digit) begin
                        a_d    = key_code;
                        disp_d = {4'd0, key_code};
                    end else if (accept && is_oper) begin
                        op_d    = oper_onehot;
                        state_d = S_GOT_OP;
                    end
                end
                S_GOT_OP: begin
                    if (accept && is_oper) begin
                        op_d = oper_onehot;
                    end else if (accept && is_digit) begin
                        b_d     = key_code;
                        disp_d  = {4'd0, key_code};
                        state_d = S_GOT_B;
                    end
                end
                S_GOT_B: begin
                    if (accept && is_digit) begin
                        b_d    = key_code;
                        disp_d = {4'd0, key_code};
                    end else if (accept && is_eq) begin
                        if (op_reg == OP_DIV && b_reg == 4'd0) begin
                            state_d    = S_ERR;
                            err_d      = 1'b1;
                            err_code_d = ERR_DIV0;
                            disp_d     = '0;
                        end else begin
                            state_d  = S_ISSUE;
                            alu_op_d = op_reg;
                            alu_a_d  = a_reg;
                            alu_b_d  = b_reg;
                        end
                    end
                end
                S_ISSUE: begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
                S_WAIT: begin
                    // busy is only trusted from the second WAIT cycle on
                    if (wait_cnt != 5'd0 && !alu_busy) begin
                        state_d        = S_SHOW;
                        result_valid_d = 1'b1;
                        if (op_reg == OP_SUB && a_reg < b_reg) begin
                            neg_d  = 1'b1;
                            disp_d = 8'(~alu_o + 8'd1);
                        end else begin
                            neg_d  = 1'b0;
                            disp_d = alu_o;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_TMO;
                        disp_d     = '0;
                    end else begin
                        wait_cnt_d = wait_cnt + 5'd1;
                    end
                end
                S_SHOW: begin
                    if (accept && is_digit) begin
                        result_valid_d = 1'b0;
                        neg_d          = 1'b0;
                        a_d            = key_code;
                        disp_d         = {4'd0, key_code};
                        state_d        = S_GOT_A;
                    end
                end
                S_ERR: begin
                    disp_d = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end

        key_ready_d = (state_d != S_ISSUE) && (state_d != S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            wait_cnt     <= '0;
            key_ready    <= 1'b1;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            disp         <= '0;
            neg          <= 1'b0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            err_code     <= '0;
        end else begin
            state        <= state_d;
            a_reg        <= a_d;
            b_reg        <= b_d;
            op_reg       <= op_d;
            wait_cnt     <= wait_cnt_d;
            key_ready    <= key_ready_d;
            alu_op       <= alu_op_d;
            alu_a        <= alu_a_d;
            alu_b        <= alu_b_d;
            disp         <= disp_d;
            neg          <= neg_d;
            result_valid <= result_valid_d;
            err          <= err_d;
            err_code     <= err_code_d;
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed self-checking bench for calc_seq_ctrl: arithmetic paths, busy handshake,
// divide-by-zero, timeout, key editing and reset during an operation.
module tb_calc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = '0;
    logic       key_ready;
    logic [3:0] alu_op, alu_a, alu_b;
    logic       alu_busy = 1'b0;
    logic [7:0] alu_o = '0;
    logic [7:0] disp;
    logic       neg, result_valid, err;
    logic [1:0] err_code;

    int n_cmp = 0;
    int n_bad = 0;

    calc_seq_ctrl #(.TIMEOUT(31)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_busy(alu_busy), .alu_o(alu_o), .disp(disp), .neg(neg),
        .result_valid(result_valid), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Present a token for one edge; returns 1 time unit after that edge.
    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL rst_key_ready got %b want 1", key_ready); end
        n_cmp++; if (alu_op !== 4'b0000) begin n_bad++; $display("FAIL rst_alu_op got %b want 0000", alu_op); end
        n_cmp++; if (alu_a !== 4'd0 || alu_b !== 4'd0) begin n_bad++; $display("FAIL rst_alu_ab got %0d/%0d want 0/0", alu_a, alu_b); end
        n_cmp++; if (disp !== 8'd0 || neg !== 1'b0) begin n_bad++; $display("FAIL rst_disp got %0d neg %b want 0 0", disp, neg); end
        n_cmp++; if (result_valid !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin n_bad++; $display("FAIL rst_flags got rv%b err%b code%b want 0 0 00", result_valid, err, err_code); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_latency();
        alu_busy = 1'b0; alu_o = 8'd7;
        press(4'd3);
        n_cmp++; if (disp !== 8'd3) begin n_bad++; $display("FAIL add_disp_a got %0d want 3", disp); end
        press(4'd10);
        press(4'd4);
        n_cmp++; if (disp !== 8'd4) begin n_bad++; $display("FAIL add_disp_b got %0d want 4", disp); end
        press(4'd14);
        n_cmp++; if (alu_op !== 4'b1000) begin n_bad++; $display("FAIL add_issue_op got %b want 1000", alu_op); end
        n_cmp++; if (alu_a !== 4'd3 || alu_b !== 4'd4) begin n_bad++; $display("FAIL add_issue_ab got %0d/%0d want 3/4", alu_a, alu_b); end
        n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL add_issue_ready got %b want 0", key_ready); end
        tick();
        n_cmp++; if (alu_op !== 4'b0000) begin n_bad++; $display("FAIL add_op_one_cycle got %b want 0000", alu_op); end
        n_cmp++; if (alu_a !== 4'd3 || alu_b !== 4'd4) begin n_bad++; $display("FAIL add_ab_hold got %0d/%0d want 3/4", alu_a, alu_b); end
        tick();
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL add_rv_early got %b want 0", result_valid); end
        tick();
        n_cmp++; if (result_valid !== 1'b1) begin n_bad++; $display("FAIL add_rv_e3 got %b want 1", result_valid); end
        n_cmp++; if (disp !== 8'd7 || neg !== 1'b0) begin n_bad++; $display("FAIL add_result got %0d neg %b want 7 0", disp, neg); end
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL add_show_ready got %b want 1", key_ready); end
    endtask

    task automatic test_sub_negative();
        alu_busy = 1'b0; alu_o = 8'hFD;
        press(4'd2);
        n_cmp++; if (result_valid !== 1'b0 || disp !== 8'd2) begin n_bad++; $display("FAIL sub_new_digit got rv%b disp %0d want 0 2", result_valid, disp); end
        press(4'd11);
        press(4'd5);
        press(4'd14);
        n_cmp++; if (alu_op !== 4'b0100) begin n_bad++; $display("FAIL sub_issue_op got %b want 0100", alu_op); end
        tick(); tick(); tick();
        n_cmp++; if (result_valid !== 1'b1 || disp !== 8'd3 || neg !== 1'b1) begin n_bad++; $display("FAIL sub_result got rv%b disp %0d neg %b want 1 3 1", result_valid, disp, neg); end
    endtask

    task automatic test_busy_wait();
        alu_busy = 1'b0; alu_o = 8'd81;
        press(4'd9);
        n_cmp++; if (neg !== 1'b0) begin n_bad++; $display("FAIL mul_neg_clear got %b want 0", neg); end
        press(4'd12);
        press(4'd9);
        press(4'd14);
        tick();
        alu_busy = 1'b1;
        @(negedge clk);
        key_valid = 1'b1; key_code = 4'd15;
        tick();
        n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL mul_wait_ready got %b want 0", key_ready); end
        tick(); tick();
        n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL mul_rv_while_busy got %b want 0", result_valid); end
        tick();
        alu_busy = 1'b0;
        key_valid = 1'b0;
        n_cmp++; if (result_valid !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL mul_still_wait got rv%b err%b want 0 0", result_valid, err); end
        tick();
        n_cmp++; if (result_valid !== 1'b1 || disp !== 8'd81 || neg !== 1'b0) begin n_bad++; $display("FAIL mul_result got rv%b disp %0d neg %b want 1 81 0", result_valid, disp, neg); end
    endtask

    task automatic test_div_zero();
        int op_seen;
        op_seen = 0;
        press(4'd8);
        press(4'd13);
        press(4'd0);
        press(4'd14);
        n_cmp++; if (err !== 1'b1 || err_code !== 2'b01) begin n_bad++; $display("FAIL div0_err got err%b code%b want 1 01", err, err_code); end
        n_cmp++; if (disp !== 8'd0 || key_ready !== 1'b1) begin n_bad++; $display("FAIL div0_disp got disp %0d ready %b want 0 1", disp, key_ready); end
        if (alu_op !== 4'b0000) op_seen++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (alu_op !== 4'b0000) op_seen++;
        end
        n_cmp++; if (op_seen !== 0) begin n_bad++; $display("FAIL div0_no_issue got %0d nonzero-op cycles want 0", op_seen); end
        press(4'd5);
        n_cmp++; if (disp !== 8'd0 || err !== 1'b1) begin n_bad++; $display("FAIL div0_digit_ignored got disp %0d err%b want 0 1", disp, err); end
        press(4'd15);
        n_cmp++; if (err !== 1'b0 || err_code !== 2'b00 || result_valid !== 1'b0) begin n_bad++; $display("FAIL clr_flags got err%b code%b rv%b want 0 00 0", err, err_code, result_valid); end
        n_cmp++; if (disp !== 8'd0 || neg !== 1'b0 || alu_op !== 4'b0000 || key_ready !== 1'b1) begin n_bad++; $display("FAIL clr_outputs got disp %0d neg %b op %b ready %b want 0 0 0000 1", disp, neg, alu_op, key_ready); end
        press(4'd10);
        n_cmp++; if (disp !== 8'd0) begin n_bad++; $display("FAIL idle_oper_ignored got %0d want 0", disp); end
    endtask

    task automatic test_timeout();
        alu_busy = 1'b1;
        press(4'd7);
        press(4'd13);
        press(4'd2);
        press(4'd14);
        for (int i = 0; i < 31; i++) tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_early got err%b want 0", err); end
        tick();
        n_cmp++; if (err !== 1'b1 || err_code !== 2'b10) begin n_bad++; $display("FAIL tmo_err got err%b code%b want 1 10", err, err_code); end
        n_cmp++; if (disp !== 8'd0 || key_ready !== 1'b1) begin n_bad++; $display("FAIL tmo_disp got disp %0d ready %b want 0 1", disp, key_ready); end
        alu_busy = 1'b0;
        press(4'd15);
        n_cmp++; if (err !== 1'b0 || err_code !== 2'b00) begin n_bad++; $display("FAIL tmo_clear got err%b code%b want 0 00", err, err_code); end
    endtask

    task automatic test_key_edit();
        alu_busy = 1'b0; alu_o = 8'd12;
        press(4'd5);
        press(4'd6);
        press(4'd11);
        press(4'd12);
        press(4'd2);
        press(4'd14);
        n_cmp++; if (alu_op !== 4'b0010 || alu_a !== 4'd6 || alu_b !== 4'd2) begin n_bad++; $display("FAIL edit_issue got op %b a %0d b %0d want 0010 6 2", alu_op, alu_a, alu_b); end
        tick(); tick(); tick();
        n_cmp++; if (disp !== 8'd12 || result_valid !== 1'b1) begin n_bad++; $display("FAIL edit_result got %0d rv%b want 12 1", disp, result_valid); end
        press(4'd3);
        press(4'd14);
        press(4'd12);
        press(4'd14);
        press(4'd4);
        press(4'd11);
        press(4'd14);
        n_cmp++; if (alu_op !== 4'b0010 || alu_a !== 4'd3 || alu_b !== 4'd4) begin n_bad++; $display("FAIL ignored_tokens got op %b a %0d b %0d want 0010 3 4", alu_op, alu_a, alu_b); end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_op();
        alu_busy = 1'b0;
        press(4'd1);
        press(4'd10);
        press(4'd1);
        press(4'd14);
        @(negedge clk); rst = 1'b1;
        tick();
        n_cmp++; if (alu_op !== 4'b0000 || key_ready !== 1'b1) begin n_bad++; $display("FAIL rst_issue got op %b ready %b want 0000 1", alu_op, key_ready); end
        @(negedge clk); rst = 1'b0;
        alu_busy = 1'b1;
        press(4'd2);
        press(4'd10);
        press(4'd3);
        press(4'd14);
        tick();
        n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wait_entry got ready %b want 0", key_ready); end
        @(negedge clk); rst = 1'b1;
        tick();
        n_cmp++; if (alu_op !== 4'b0000 || key_ready !== 1'b1 || disp !== 8'd0 || alu_a !== 4'd0) begin n_bad++; $display("FAIL rst_wait got op %b ready %b disp %0d a %0d want 0000 1 0 0", alu_op, key_ready, disp, alu_a); end
        @(negedge clk); rst = 1'b0;
        alu_busy = 1'b0;
        press(4'd11);
        n_cmp++; if (disp !== 8'd0) begin n_bad++; $display("FAIL rst_idle_oper got %0d want 0", disp); end
        press(4'd4);
        n_cmp++; if (disp !== 8'd4) begin n_bad++; $display("FAIL rst_idle_digit got %0d want 4", disp); end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_sub_negative();
        test_busy_wait();
        test_div_zero();
        test_timeout();
        test_key_edit();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
